// File: rtl/addsub_accumulator.sv
// Registered add/subtract accumulator with valid/ready on both sides.
// One command per cycle is accepted whenever the result register is empty
// or being drained in the same cycle; results appear one cycle later.
module addsub_accumulator #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [CNTW-1:0]  cmd_count
);

  typedef enum logic [1:0] {
    OpAdd   = 2'b00,
    OpSub   = 2'b01,
    OpLoad  = 2'b10,
    OpClear = 2'b11
  } op_e;

  op_e op;
  assign op = op_e'(in_op);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic [WIDTH-1:0] res_acc;
  logic             res_carry;
  logic             res_ovf;
  logic             accept;

  // No skid buffer: accept only when the result slot is free or draining now.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Combinational datapath: result of applying the current command to acc.
  always_comb begin
    sum_add   = {1'b0, acc_q} + {1'b0, in_data};
    // Subtract as acc + ~b + 1 so the carry reads as not-borrow.
    sum_sub   = {1'b0, acc_q} + {1'b0, ~in_data} + (WIDTH + 1)'(1);
    res_acc   = '0;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    unique case (op)
      OpAdd: begin
        {res_carry, res_acc} = sum_add;
        res_ovf = (acc_q[WIDTH-1] == in_data[WIDTH-1]) &&
                  (sum_add[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OpSub: begin
        {res_carry, res_acc} = sum_sub;
        res_ovf = (acc_q[WIDTH-1] != in_data[WIDTH-1]) &&
                  (sum_sub[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OpLoad:  res_acc = in_data;
      OpClear: res_acc = '0;
    endcase
  end

  // Next-state: load a new result on accept, otherwise drain on out_ready.
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (accept) begin
      acc_d   = res_acc;
      carry_d = res_carry;
      ovf_d   = res_ovf;
      zero_d  = (res_acc == '0);
      valid_d = 1'b1;
      if (cnt_q != {CNTW{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (out_ready) begin
      // Data registers keep their last value after consumption.
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_acc   = acc_q;
  assign out_carry = carry_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign cmd_count = cnt_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Self-checking bench for addsub_accumulator: directed plan scenarios plus
// randomized handshake traffic against an integer-arithmetic model.
module tb_addsub_accumulator;

  localparam int W    = 4;
  localparam int CW   = 8;
  localparam int M    = 1 << W;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_acc;
  logic          out_carry;
  logic          out_ovf;
  logic          out_zero;
  logic [CW-1:0] cmd_count;

  addsub_accumulator #(
    .WIDTH(W),
    .CNTW (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_acc  (out_acc),
    .out_carry(out_carry),
    .out_ovf  (out_ovf),
    .out_zero (out_zero),
    .cmd_count(cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (registered outputs as seen after an edge).
  int m_acc;
  int m_cnt;
  bit m_c, m_v, m_z, m_valid;

  logic [W+3:0] dut_vec;
  assign dut_vec = {out_valid, out_acc, out_carry, out_ovf, out_zero};

  function automatic logic [W+3:0] exp_vec();
    logic [W-1:0] a;
    a = m_acc[W-1:0];
    return {m_valid, a, m_c, m_v, m_z};
  endfunction

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_c = 0; m_v = 0; m_z = 0; m_valid = 0;
  endtask

  // Plain integer arithmetic: unsigned result range gives carry, signed
  // interpretation range gives overflow.
  task automatic model_apply(input int op, input int d);
    int sa, sd, sr;
    sa = (m_acc >= M / 2) ? m_acc - M : m_acc;
    sd = (d >= M / 2) ? d - M : d;
    case (op)
      0: begin
        m_c   = (m_acc + d) >= M;
        sr    = sa + sd;
        m_v   = (sr < -(M / 2)) || (sr > M / 2 - 1);
        m_acc = (m_acc + d) % M;
      end
      1: begin
        m_c   = m_acc >= d;
        sr    = sa - sd;
        m_v   = (sr < -(M / 2)) || (sr > M / 2 - 1);
        m_acc = (m_acc - d + M) % M;
      end
      2: begin m_acc = d; m_c = 0; m_v = 0; end
      default: begin m_acc = 0; m_c = 0; m_v = 0; end
    endcase
    m_z     = (m_acc == 0);
    m_valid = 1;
    if (m_cnt < CMAX) m_cnt++;
  endtask

  // Present one command and wait (bounded) for it to be taken; returns at
  // edge+1 after the accepting edge with in_valid dropped.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] d, output bit ok);
    ok       = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_data = '0; out_ready = 1'b0;
    model_reset();
    #3;
    n_checks++;
    if ({dut_vec, cmd_count} !== {exp_vec(), CW'(0)})
      $display("FAIL reset_state: got out=%b cnt=%0d want out=%b cnt=0", dut_vec, cmd_count,
               exp_vec());
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_directed();
    bit ok;
    // op, data, expected acc, carry, ovf, zero
    int tbl[8][6] = '{
      '{2, 6, 6, 0, 0, 0}, '{0, 6, 12, 0, 1, 0}, '{2, 3, 3, 0, 0, 0}, '{1, 5, 14, 0, 0, 0},
      '{0, 2, 0, 1, 0, 1}, '{2, 10, 10, 0, 0, 0}, '{0, 8, 2, 1, 1, 0}, '{3, 5, 0, 0, 0, 1}
    };
    logic [W+3:0] want;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i][0][1:0], tbl[i][1][W-1:0], ok);
      model_apply(tbl[i][0], tbl[i][1]);
      want = {1'b1, tbl[i][2][W-1:0], tbl[i][3][0], tbl[i][4][0], tbl[i][5][0]};
      n_checks++;
      if ({ok, dut_vec, cmd_count} !== {1'b1, want, CW'(m_cnt)})
        $display("FAIL directed_%0d: got ok=%b out=%b cnt=%0d want ok=1 out=%b cnt=%0d", i, ok,
                 dut_vec, cmd_count, want, m_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    logic [W+3:0] held;
    int cnt;
    out_ready = 1'b1;
    issue(2'b00, 4'd3, ok);
    model_apply(0, 3);
    n_checks++;
    if ({ok, dut_vec} !== {1'b1, exp_vec()})
      $display("FAIL bp_first: got ok=%b out=%b want out=%b", ok, dut_vec, exp_vec());
    else n_pass++;
    out_ready = 1'b0;
    held = exp_vec();
    cnt  = m_cnt;
    in_valid = 1'b1; in_op = 2'b01; in_data = 4'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({in_ready, dut_vec, cmd_count} !== {1'b0, held, CW'(cnt)})
        $display("FAIL bp_hold_%0d: got rdy=%b out=%b cnt=%0d want rdy=0 out=%b cnt=%0d", i,
                 in_ready, dut_vec, cmd_count, held, cnt);
      else n_pass++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_apply(1, 2);
    n_checks++;
    if ({dut_vec, cmd_count} !== {exp_vec(), CW'(m_cnt)})
      $display("FAIL bp_second: got out=%b cnt=%0d want out=%b cnt=%0d", dut_vec, cmd_count,
               exp_vec(), m_cnt);
    else n_pass++;
    @(posedge clk); #1;
    m_valid = 0;
    n_checks++;
    if (dut_vec !== exp_vec())
      $display("FAIL consume_only: got out=%b want out=%b", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_streaming();
    bit ok;
    out_ready = 1'b1;
    issue(2'b10, 4'd0, ok);
    model_apply(2, 0);
    n_checks++;
    if ({ok, dut_vec} !== {1'b1, exp_vec()})
      $display("FAIL stream_load: got ok=%b out=%b want out=%b", ok, dut_vec, exp_vec());
    else n_pass++;
    in_valid = 1'b1; in_op = 2'b00; in_data = 4'd1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      model_apply(0, 1);
      n_checks++;
      if ({dut_vec, cmd_count} !== {exp_vec(), CW'(m_cnt)} || out_acc !== W'(k))
        $display("FAIL stream_%0d: got out=%b cnt=%0d want out=%b cnt=%0d", k, dut_vec,
                 cmd_count, exp_vec(), m_cnt);
      else n_pass++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    bit pending = 0;
    bit exp_acc;
    for (int i = 0; i < 250; i++) begin
      if (!pending) begin
        in_valid = ($urandom % 4) != 0;
        in_op    = 2'($urandom);
        in_data  = W'($urandom);
      end
      out_ready = ($urandom % 3) != 0;
      #1;
      n_checks++;
      if (in_ready !== (!m_valid || out_ready))
        $display("FAIL rand_ready_%0d: got %b want %b", i, in_ready, !m_valid || out_ready);
      else n_pass++;
      exp_acc = in_valid && (!m_valid || out_ready);
      @(posedge clk); #1;
      if (exp_acc) model_apply(int'(in_op), int'(in_data));
      else if (out_ready) m_valid = 0;
      pending = in_valid && !exp_acc;
      n_checks++;
      if ({dut_vec, cmd_count} !== {exp_vec(), CW'(m_cnt)})
        $display("FAIL rand_out_%0d: got out=%b cnt=%0d want out=%b cnt=%0d", i, dut_vec,
                 cmd_count, exp_vec(), m_cnt);
      else n_pass++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 2'b11; in_data = 4'd7;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      model_apply(3, 7);
      n_checks++;
      if (cmd_count !== CW'(m_cnt))
        $display("FAIL sat_cnt_%0d: got %0d want %0d", i, cmd_count, m_cnt);
      else n_pass++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (cmd_count !== CW'(CMAX)) $display("FAIL sat_final: got %0d want %0d", cmd_count, CMAX);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [W+3:0] want;
    out_ready = 1'b1;
    issue(2'b10, 4'd9, ok);
    model_apply(2, 9);
    out_ready = 1'b0;
    n_checks++;
    if ({ok, dut_vec} !== {1'b1, exp_vec()})
      $display("FAIL rmid_load: got ok=%b out=%b want out=%b", ok, dut_vec, exp_vec());
    else n_pass++;
    // Assert reset well before the next rising edge.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({dut_vec, cmd_count} !== {exp_vec(), CW'(0)})
      $display("FAIL rmid_async: got out=%b cnt=%0d want out=%b cnt=0", dut_vec, cmd_count,
               exp_vec());
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    issue(2'b00, 4'd4, ok);
    model_apply(0, 4);
    want = {1'b1, 4'd4, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if ({ok, dut_vec, cmd_count} !== {1'b1, want, CW'(1)})
      $display("FAIL rmid_after: got ok=%b out=%b cnt=%0d want out=%b cnt=1", ok, dut_vec,
               cmd_count, want);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_pressure();
    test_streaming();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/addsub_accumulator.md
Name: addsub_accumulator

Overview:
Registered accumulator stage built around the team's 4-bit add/subtract datapath. It accepts a stream of operand/opcode commands over a valid/ready handshake and applies each command to an internal accumulator. Each result, with carry, signed-overflow and zero flags, goes to a one-entry output register with its own valid/ready handshake. It sits between an operand sequencer upstream and any result consumer downstream, and turns the combinational add/sub into a pipelined, back-pressurable unit.

Parameters:
WIDTH, 4, datapath width of operand and accumulator in bits
CNTW, 8, width of the saturating accepted-command counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream command valid
in_ready  output  1  block can accept a command this cycle
in_op  input  2  opcode: 00 add, 01 subtract, 10 load, 11 clear
in_data  input  WIDTH  operand
out_valid  output  1  result register holds an unconsumed result
out_ready  input  1  downstream accepts the result this cycle
out_acc  output  WIDTH  accumulator value after the command
out_carry  output  1  carry-out (add) / not-borrow (subtract)
out_ovf  output  1  two's-complement signed overflow
out_zero  output  1  out_acc == 0
cmd_count  output  CNTW  number of accepted commands, saturating

Behaviour:
- Reset (rst_n=0, asynchronous, effective immediately): acc=0, out_valid=0, out_acc=0, out_carry=0, out_ovf=0, out_zero=0, cmd_count=0. in_ready is 1 as soon as reset is released. Reset mid-transaction discards any pending result; no output handshake completes.
- in_ready = !out_valid || out_ready, combinational. There is no skid buffer.
- Accept: in_valid && in_ready at a rising edge. Nothing else changes acc or cmd_count.
- Add (00): {carry, acc'} = acc + in_data. Sum is WIDTH+1 bits; carry is bit WIDTH.
- Subtract (01): {carry, acc'} = acc + ~in_data + 1. carry=1 means no borrow (acc >= in_data unsigned).
- Overflow for add and subtract: ovf=1 when the signed result sign differs from the mathematically correct sign. For add: operand signs equal and result sign different. For subtract: acc sign != in_data sign and result sign != acc sign.
- Load (10): acc'=in_data, carry=0, ovf=0.
- Clear (11): acc'=0, carry=0, ovf=0; in_data is ignored.
- out_zero = (acc' == 0) for every opcode.
- Latency is 1 cycle. On the edge that accepts a command, acc and out_acc/out_carry/out_ovf/out_zero load the new values and out_valid becomes 1. out_acc always equals acc.
- Output hold: while out_valid=1 and out_ready=0, all out_* outputs are stable and in_ready=0.
- Consume only: out_valid && out_ready with no accepted command clears out_valid next edge. out_* data keeps its last value.
- Simultaneous consume and accept in the same cycle: out_valid stays 1 and out_* load the new result. This gives full throughput of one command per cycle.
- Wrap-around: acc wraps modulo 2^WIDTH and carry/ovf report the wrap. No saturation of acc.
- cmd_count increments by 1 per accepted command and holds at 2^CNTW-1.
- in_valid is ignored while in_ready=0. The upstream must hold in_op/in_data stable until accepted.

Test Plan:
- Reset then load 6, add 6 (out_ready=1) -> results 6 (c0 v0 z0), then 12 (1100, c0, ovf1, z0); cmd_count=2.
- Load 3, subtract 5 -> out_acc=14 (1110), carry0 (borrow), ovf0. Then add 2 -> out_acc=0, carry1, ovf0, zero1.
- Load 10, add 8 -> out_acc=2, carry1, ovf1.
  - Then clear -> out_acc=0, carry0, ovf0, zero1.
- Back-pressure: hold out_ready=0 after one result and present a second command for 3 cycles -> in_ready=0 throughout, out_* stable, acc unchanged. Raise out_ready -> second command accepted that cycle, new result next edge, out_valid never drops.
- Streaming: in_valid=1 and out_ready=1 for 5 consecutive add-1 commands from load 0 -> out_acc 1,2,3,4,5 on consecutive cycles; cmd_count increments every cycle.
- Reset mid-operation: assert rst_n=0 between edges while out_valid=1 and acc=9 -> out_valid, acc and cmd_count go to 0 immediately without a clock edge. After release, add 4 -> out_acc=4.
